// File: rtl/door_sequencer.sv
// door_sequencer: door open/dwell/close cycle controller with obstruction reopen and limit-switch fault.
// Optional nudge (obstruction lockout after MAX_REOPEN reopens) enabled by DOOR_NUDGE_EN.
module door_sequencer #(
  parameter int MAX_REOPEN = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic open_req,
  input  logic obstruct,
  input  logic open_lim,
  input  logic closed_lim,
  input  logic T,
  output logic KT,
  output logic door_open_cmd,
  output logic door_close_cmd,
  output logic door_busy,
  output logic door_done,
  output logic fault,
  output logic nudge
);
`ifdef DOOR_NUDGE_EN
  localparam logic NUDGE_EN = 1'b1;
`else
  localparam logic NUDGE_EN = 1'b0;
`endif
  typedef enum logic [2:0] {
    S_IDLE, S_OPENING, S_KICK, S_DWELL, S_CLOSING, S_DONE, S_FAULT
  } state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ext_q, ext_d, ign, ob;
  // Once the reopen budget is spent, obstruction no longer extends or reverses
  assign ign = NUDGE_EN && (cnt_q >= CNT_W'(MAX_REOPEN));
  assign ob  = obstruct && !ign;
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && open_lim && closed_lim) state_d = S_FAULT;
    else
      case (state_q)
        S_IDLE:    if (open_req) state_d = open_lim ? S_KICK : S_OPENING;
        S_OPENING: if (open_lim) state_d = S_KICK;
        S_KICK:    state_d = S_DWELL;
        S_DWELL:   if (T) state_d = (ext_q || ob) ? S_KICK : S_CLOSING;
        S_CLOSING: state_d = closed_lim ? S_DONE : ob ? S_OPENING : S_CLOSING;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_FAULT;
      endcase
  end
  assign ext_d = (state_q == S_KICK) ? 1'b0 : (state_q == S_DWELL && ob) ? 1'b1 : ext_q;
  assign cnt_d = (state_q == S_DONE) ? '0 :
                 (state_q == S_CLOSING && state_d == S_OPENING) ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) :
                 cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      ext_q          <= 1'b0;
      KT             <= 1'b0;
      door_open_cmd  <= 1'b0;
      door_close_cmd <= 1'b0;
      door_busy      <= 1'b0;
      door_done      <= 1'b0;
      fault          <= 1'b0;
      nudge          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ext_q          <= ext_d;
      KT             <= state_d == S_KICK;
      door_open_cmd  <= state_d == S_OPENING;
      door_close_cmd <= state_d == S_CLOSING;
      door_busy      <= state_d != S_IDLE;
      door_done      <= state_d == S_DONE;
      fault          <= state_d == S_FAULT;
      nudge          <= NUDGE_EN && (cnt_d >= CNT_W'(MAX_REOPEN)) &&
                        (state_d == S_DWELL || state_d == S_CLOSING);
    end
  end
endmodule

// File: tb/tb_door_sequencer.sv
// tb_door_sequencer: directed scenarios plus random traffic against a behavioural door-cycle model.
module tb_door_sequencer;
  localparam int MAXR = 4;
`ifdef DOOR_NUDGE_EN
  localparam bit NUDGE = 1'b1;
`else
  localparam bit NUDGE = 1'b0;
`endif
  localparam int IDLE = 0, OPEN = 1, KICK = 2, DWELL = 3, CLOSE = 4, DONE = 5, FLT = 6;
  logic clk = 1'b0;
  logic rst, req, obs, ol, cl, t;
  logic kt, oc, cc, busy, done, flt, ndg;
  int n_chk = 0, n_fail = 0;
  int ph, reopen, pos, tcnt, dwell_len;
  bit ext, force_both, obs_mode, oc_prev;
  bit e_kt, e_open, e_close, e_busy, e_done, e_fault, e_nudge;
  int kt_n, done_n, open_n, oc_n, nudge_n;
  always #5 clk = ~clk;
  door_sequencer #(.MAX_REOPEN(MAXR), .CNT_W(3)) dut (
    .clk(clk), .reset(rst), .open_req(req), .obstruct(obs), .open_lim(ol), .closed_lim(cl), .T(t),
    .KT(kt), .door_open_cmd(oc), .door_close_cmd(cc), .door_busy(busy), .door_done(done),
    .fault(flt), .nudge(ndg));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_step();
    bit ob;
    ob = obs && !(NUDGE && reopen >= MAXR);
    if (rst) begin
      ph = IDLE; reopen = 0; ext = 0;
    end else if (ph != IDLE && ol && cl) ph = FLT;
    else if (ph == IDLE) begin
      if (req) ph = ol ? KICK : OPEN;
    end else if (ph == OPEN) begin
      if (ol) ph = KICK;
    end else if (ph == KICK) begin
      ext = 0; ph = DWELL;
    end else if (ph == DWELL) begin
      ext = ext || ob;
      if (t) ph = ext ? KICK : CLOSE;
    end else if (ph == CLOSE) begin
      if (cl) ph = DONE;
      else if (ob) begin
        ph = OPEN;
        reopen = (reopen < 7) ? reopen + 1 : 7;
      end
    end else if (ph == DONE) begin
      reopen = 0; ph = IDLE;
    end
    e_kt = ph == KICK; e_open = ph == OPEN; e_close = ph == CLOSE; e_busy = ph != IDLE;
    e_done = ph == DONE; e_fault = ph == FLT;
    e_nudge = NUDGE && reopen >= MAXR && (ph == DWELL || ph == CLOSE);
  endtask
  task automatic tick(input bit rnd);
    @(posedge clk);
    m_step();
    #1;
    chk("kt", kt, e_kt);
    chk("open_cmd", oc, e_open);
    chk("close_cmd", cc, e_close);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("fault", flt, e_fault);
    chk("nudge", ndg, e_nudge);
    kt_n += int'(kt); done_n += int'(done); oc_n += int'(oc); nudge_n += int'(ndg);
    if (oc && !oc_prev) open_n++;
    oc_prev = oc;
    if (rnd) begin
      rst = ($urandom_range(0, 499) == 0) || (flt && $urandom_range(0, 29) == 0);
      req = $urandom_range(0, 5) == 0;
      obs = $urandom_range(0, 7) == 0;
      force_both = $urandom_range(0, 599) == 0;
    end
    if (obs_mode) obs = e_close;
    if (e_open && pos < 5) pos++;
    if (e_close && pos > 0) pos--;
    // the timer keeps a stale T high through the kick cycle before restarting
    if (e_kt) tcnt = rnd ? int'($urandom_range(2, 10)) : dwell_len;
    else if (tcnt > 0) begin
      t = 0; tcnt--;
      if (tcnt == 0) t = 1;
    end
    ol = force_both || pos == 5;
    cl = force_both || pos == 0;
  endtask
  task automatic clr();
    kt_n = 0; done_n = 0; open_n = 0; oc_n = 0; nudge_n = 0;
  endtask
  task automatic run_cycle(input int obs_at, input int lim, output bit fin);
    fin = 0;
    req = 1; tick(0); req = 0;
    for (int i = 0; i < lim; i++) begin
      if (!obs_mode) obs = (i == obs_at);
      tick(0);
      if (done) begin
        fin = 1;
        break;
      end
    end
    obs = 0;
  endtask
  initial begin
    bit fin, found;
    rst = 1; req = 0; obs = 0; t = 0; pos = 0; ol = 0; cl = 1; force_both = 0; obs_mode = 0;
    tcnt = 0; dwell_len = 20; ph = IDLE; reopen = 0; ext = 0; oc_prev = 0; clr();
    tick(0); tick(0);
    chk("reset_busy", busy, 0);
    chk("reset_fault", flt, 0);
    rst = 0; tick(0);
    clr(); run_cycle(-1, 200, fin);
    chk("basic_done", fin, 1);
    chk("basic_kt_pulses", kt_n, 1);
    chk("basic_open_cycles", oc_n, 5);
    tick(0);
    chk("basic_idle", busy, 0);
    clr(); run_cycle(10, 300, fin);
    chk("dwell_obs_done", fin, 1);
    chk("dwell_obs_kt_pulses", kt_n, 2);
    chk("dwell_obs_opens", open_n, 1);
    tick(0);
    clr(); run_cycle(27, 300, fin);
    chk("close_obs_done", fin, 1);
    chk("close_obs_kt_pulses", kt_n, 2);
    chk("close_obs_opens", open_n, 2);
    tick(0);
    clr(); obs_mode = 1; dwell_len = 4;
    run_cycle(-1, 600, fin);
    obs_mode = 0; obs = 0;
    chk("nudge_done", fin, NUDGE);
    chk("nudge_seen", nudge_n > 0, NUDGE);
    chk("reopen_at_least_5", open_n >= 5, 1);
    rst = 1; tick(0); rst = 0; tick(0);
    dwell_len = 20;
    req = 1; tick(0); req = 0; tick(0);
    force_both = 1; ol = 1; cl = 1;
    tick(0);
    chk("fault_set", flt, 1);
    chk("fault_open_off", oc, 0);
    chk("fault_close_off", cc, 0);
    repeat (50) tick(0);
    chk("fault_sticky", flt, 1);
    force_both = 0; rst = 1; tick(0);
    chk("fault_cleared", flt, 0);
    chk("fault_reset_busy", busy, 0);
    rst = 0; tick(0);
    found = 0;
    req = 1; tick(0); req = 0;
    for (int i = 0; i < 200; i++) begin
      tick(0);
      if (t && busy && !oc && !cc && !kt) begin
        found = 1;
        break;
      end
    end
    chk("dwell_t_reached", found, 1);
    rst = 1; clr(); tick(0);
    chk("rst_dwell_busy", busy, 0);
    chk("rst_dwell_kt", kt, 0);
    rst = 0;
    repeat (5) tick(0);
    chk("rst_no_done", done_n, 0);
    chk("rst_no_kt", kt_n, 0);
    repeat (15000) tick(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
